// File: rtl/framebuffer_write_sequencer.sv
// Single write-port owner for the paint framebuffer: arbitrates a full-screen
// clear and a clipped square brush stamp, presenting one registered write slot per cycle.
module framebuffer_write_sequencer #(
    parameter int PALETTE_BITS = 2,
    parameter int WIDTH        = 100,
    parameter int HEIGHT       = 100,
    parameter int BRUSH_RADIUS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    input  logic [PALETTE_BITS-1:0] clear_color,
    input  logic                    paint_req,
    input  logic [9:0]              paint_x,
    input  logic [9:0]              paint_y,
    input  logic [PALETTE_BITS-1:0] paint_color,
    output logic                    busy,
    output logic                    done,
    output logic [9:0]              writeX,
    output logic [9:0]              writeY,
    output logic                    write_enable,
    output logic [PALETTE_BITS-1:0] write_color
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int OW = (BRUSH_RADIUS > 0) ? $clog2(2 * BRUSH_RADIUS + 1) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [OW-1:0] O_LAST = OW'(2 * BRUSH_RADIUS);

    typedef enum logic [1:0] {IDLE, CLEAR, BRUSH} state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } slot_t;

    state_t                  state, state_nx;
    logic [XW-1:0]           x_cnt, x_nx;
    logic [YW-1:0]           y_cnt, y_nx;
    logic [OW-1:0]           ox_cnt, ox_nx;
    logic [OW-1:0]           oy_cnt, oy_nx;
    logic [9:0]              cx_q, cx_nx;
    logic [9:0]              cy_q, cy_nx;
    logic                    busy_nx, done_nx, we_nx;
    logic [9:0]              wx_nx, wy_nx;
    logic [PALETTE_BITS-1:0] color_nx;
    slot_t                   slot;

    // Offsets run 0..2R and are re-centred here; the 11-bit signed sum
    // lets a centre near the left/top edge go negative and be clipped.
    function automatic slot_t brush_slot(input logic [9:0]    cx,
                                         input logic [9:0]    cy,
                                         input logic [OW-1:0] ox,
                                         input logic [OW-1:0] oy);
        logic signed [10:0] px;
        logic signed [10:0] py;
        slot_t              s;
        px   = signed'({1'b0, cx}) + signed'(11'(ox)) - signed'(11'(BRUSH_RADIUS));
        py   = signed'({1'b0, cy}) + signed'(11'(oy)) - signed'(11'(BRUSH_RADIUS));
        s.x  = px[9:0];
        s.y  = py[9:0];
        s.en = !px[10] && (unsigned'(px) < 11'(WIDTH)) &&
               !py[10] && (unsigned'(py) < 11'(HEIGHT));
        return s;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        x_nx     = x_cnt;
        y_nx     = y_cnt;
        ox_nx    = ox_cnt;
        oy_nx    = oy_cnt;
        cx_nx    = cx_q;
        cy_nx    = cy_q;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        we_nx    = 1'b0;
        wx_nx    = writeX;
        wy_nx    = writeY;
        color_nx = write_color;
        slot     = '0;

        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nx = CLEAR;
                    x_nx     = '0;
                    y_nx     = '0;
                    busy_nx  = 1'b1;
                    we_nx    = 1'b1;
                    wx_nx    = '0;
                    wy_nx    = '0;
                    color_nx = clear_color;
                end else if (paint_req) begin
                    state_nx = BRUSH;
                    cx_nx    = paint_x;
                    cy_nx    = paint_y;
                    ox_nx    = '0;
                    oy_nx    = '0;
                    slot     = brush_slot(paint_x, paint_y, '0, '0);
                    busy_nx  = 1'b1;
                    we_nx    = slot.en;
                    wx_nx    = slot.x;
                    wy_nx    = slot.y;
                    color_nx = paint_color;
                end
            end

            CLEAR: begin
                if (x_cnt == X_LAST && y_cnt == Y_LAST) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    if (x_cnt == X_LAST) begin
                        x_nx = '0;
                        y_nx = y_cnt + YW'(1);
                    end else begin
                        x_nx = x_cnt + XW'(1);
                    end
                    busy_nx = 1'b1;
                    we_nx   = 1'b1;
                    wx_nx   = 10'(x_nx);
                    wy_nx   = 10'(y_nx);
                end
            end

            BRUSH: begin
                if (ox_cnt == O_LAST && oy_cnt == O_LAST) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    if (ox_cnt == O_LAST) begin
                        ox_nx = '0;
                        oy_nx = oy_cnt + OW'(1);
                    end else begin
                        ox_nx = ox_cnt + OW'(1);
                    end
                    slot    = brush_slot(cx_q, cy_q, ox_nx, oy_nx);
                    busy_nx = 1'b1;
                    we_nx   = slot.en;
                    wx_nx   = slot.x;
                    wy_nx   = slot.y;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            ox_cnt       <= '0;
            oy_cnt       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            write_enable <= 1'b0;
            writeX       <= '0;
            writeY       <= '0;
            write_color  <= '0;
        end else begin
            state        <= state_nx;
            x_cnt        <= x_nx;
            y_cnt        <= y_nx;
            ox_cnt       <= ox_nx;
            oy_cnt       <= oy_nx;
            cx_q         <= cx_nx;
            cy_q         <= cy_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            write_enable <= we_nx;
            writeX       <= wx_nx;
            writeY       <= wy_nx;
            write_color  <= color_nx;
        end
    end

endmodule

// File: tb/tb_framebuffer_write_sequencer.sv
// Self-checking bench: expected write-slot streams are built from the raster
// and brush rules with plain integer arithmetic and compared slot by slot.
module tb_framebuffer_write_sequencer;

    localparam int PB = 2;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int R  = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic [PB-1:0] clear_color;
    logic          paint_req;
    logic [9:0]    paint_x;
    logic [9:0]    paint_y;
    logic [PB-1:0] paint_color;
    logic          busy;
    logic          done;
    logic [9:0]    writeX;
    logic [9:0]    writeY;
    logic          write_enable;
    logic [PB-1:0] write_color;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int x;
        int y;
        bit en;
        int color;
    } exp_slot_t;

    exp_slot_t exp_q[$];

    framebuffer_write_sequencer #(
        .PALETTE_BITS(PB),
        .WIDTH       (W),
        .HEIGHT      (H),
        .BRUSH_RADIUS(R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .paint_req   (paint_req),
        .paint_x     (paint_x),
        .paint_y     (paint_y),
        .paint_color (paint_color),
        .busy        (busy),
        .done        (done),
        .writeX      (writeX),
        .writeY      (writeY),
        .write_enable(write_enable),
        .write_color (write_color)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build_clear(input int c);
        exp_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back('{x: x, y: y, en: 1'b1, color: c});
    endtask

    task automatic build_brush(input int cx, input int cy, input int c);
        exp_q.delete();
        for (int dy = -R; dy <= R; dy++)
            for (int dx = -R; dx <= R; dx++) begin
                int px = cx + dx;
                int py = cy + dy;
                bit en = (px >= 0) && (px < W) && (py >= 0) && (py < H);
                exp_q.push_back('{x: px, y: py, en: en, color: c});
            end
    endtask

    // Waits for the accepting edge, then checks every expected slot and the done cycle.
    // keep_paint leaves paint_req high; mid_px (>=0) rewrites paint_x partway through.
    task automatic run_op(input string tag, input bit keep_paint, input int mid_px);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        if (!keep_paint) paint_req = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s done[%0d]", tag, i), 32'(done), 32'd0);
            check($sformatf("%s we[%0d]", tag, i), 32'(write_enable), 32'(exp_q[i].en));
            if (exp_q[i].en) begin
                check($sformatf("%s x[%0d]", tag, i), 32'(writeX), 32'(exp_q[i].x));
                check($sformatf("%s y[%0d]", tag, i), 32'(writeY), 32'(exp_q[i].y));
                check($sformatf("%s color[%0d]", tag, i), 32'(write_color), 32'(exp_q[i].color));
            end
            if (i == 5 && mid_px >= 0) paint_x = 10'(mid_px);
        end
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " done busy"}, 32'(busy), 32'd0);
        check({tag, " done we"}, 32'(write_enable), 32'd0);
    endtask

    task automatic request_paint(input int x, input int y, input int c);
        paint_req   = 1'b1;
        paint_x     = 10'(x);
        paint_y     = 10'(y);
        paint_color = PB'(c);
    endtask

    initial begin
        rst         = 1'b1;
        clear_req   = 1'b0;
        clear_color = '0;
        paint_req   = 1'b0;
        paint_x     = '0;
        paint_y     = '0;
        paint_color = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst we", 32'(write_enable), 32'd0);
        check("rst x", 32'(writeX), 32'd0);
        check("rst y", 32'(writeY), 32'd0);
        check("rst color", 32'(write_color), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full clear, colour 2, then done lasts exactly one cycle
        clear_req   = 1'b1;
        clear_color = 2'd2;
        build_clear(2);
        run_op("clear", 1'b0, -1);
        @(negedge clk);
        check("clear done width", 32'(done), 32'd0);
        check("clear idle busy", 32'(busy), 32'd0);

        // Interior brush
        request_paint(4, 2, 1);
        build_brush(4, 2, 1);
        run_op("interior", 1'b0, -1);

        // Corner clip
        @(negedge clk);
        request_paint(0, 0, 3);
        build_brush(0, 0, 3);
        run_op("corner", 1'b0, -1);

        // Priority: clear wins, paint_x changed mid-clear, paint held through done
        @(negedge clk);
        clear_req   = 1'b1;
        clear_color = 2'd3;
        request_paint(4, 2, 1);
        build_clear(3);
        run_op("prio clear", 1'b1, 6);
        build_brush(6, 2, 1);
        run_op("prio brush", 1'b0, -1);

        // Reset during write 10 of a clear
        @(negedge clk);
        clear_req   = 1'b1;
        clear_color = 2'd1;
        build_clear(1);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("rstmid we[%0d]", i), 32'(write_enable), 32'd1);
            check($sformatf("rstmid x[%0d]", i), 32'(writeX), 32'(exp_q[i].x));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid we", 32'(write_enable), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid done", 32'(done), 32'd0);
        check("rstmid color", 32'(write_color), 32'd0);
        @(negedge clk);
        check("rstmid no done", 32'(done), 32'd0);
        check("rstmid still idle", 32'(busy), 32'd0);
        request_paint(4, 2, 1);
        build_brush(4, 2, 1);
        run_op("post-rst brush", 1'b0, -1);

        // Centre wholly off-screen
        @(negedge clk);
        request_paint(20, 20, 2);
        build_brush(20, 20, 2);
        run_op("offscreen", 1'b0, -1);

        // Randomised brushes around and beyond the edges, plus a random clear
        for (int k = 0; k < 8; k++) begin
            int rx = int'($urandom_range(0, W + 2));
            int ry = int'($urandom_range(0, H + 2));
            int rc = int'($urandom_range(0, 3));
            @(negedge clk);
            request_paint(rx, ry, rc);
            build_brush(rx, ry, rc);
            run_op($sformatf("rand%0d(%0d,%0d)", k, rx, ry), 1'b0, -1);
        end
        begin
            int rc = int'($urandom_range(0, 3));
            @(negedge clk);
            clear_req   = 1'b1;
            clear_color = PB'(rc);
            build_clear(rc);
            run_op("rand clear", 1'b0, -1);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Run-time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/framebuffer_write_sequencer.md
Name: framebuffer_write_sequencer

Overview:
- Single write-port owner for the paint framebuffer.
- Two requesters share the port:
  - a clear engine that fills every pixel with one palette colour;
  - a brush engine that stamps a square of side 2*BRUSH_RADIUS+1 centred on the cursor.
- Outputs connect directly to the framebuffer's writeX/writeY/write_enable/write_color inputs.
- Clipping is done here so the framebuffer never sees an out-of-range address.

Parameters:
- PALETTE_BITS, 2, width of a palette index.
- WIDTH, 100, framebuffer width in pixels.
- HEIGHT, 100, framebuffer height in pixels.
- BRUSH_RADIUS, 2, brush half-size; brush side is 2*BRUSH_RADIUS+1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear_req  in  1  request full-screen clear; level, sampled only in IDLE.
- clear_color  in  PALETTE_BITS  clear colour, latched on acceptance.
- paint_req  in  1  request brush stamp; level, sampled only in IDLE.
- paint_x  in  10  brush centre X, latched on acceptance.
- paint_y  in  10  brush centre Y, latched on acceptance.
- paint_color  in  PALETTE_BITS  brush colour, latched on acceptance.
- busy  out  1  high while a CLEAR or BRUSH operation is in progress.
- done  out  1  one-cycle pulse after the final write slot of an operation.
- writeX  out  10  framebuffer write X.
- writeY  out  10  framebuffer write Y.
- write_enable  out  1  framebuffer write strobe.
- write_color  out  PALETTE_BITS  framebuffer write data.

Behaviour:
- Registered outputs: all outputs are registers.
- Reset values: busy=0, done=0, write_enable=0, writeX=0, writeY=0, write_color=0, state=IDLE.
- States: IDLE, CLEAR, BRUSH.
- IDLE, on a clock edge:
  - clear_req=1 -> latch clear_color, enter CLEAR.
  - else paint_req=1 -> latch paint_x/paint_y/paint_color, enter BRUSH.
  - Clear has priority when both requests are high; the losing paint_req is not queued. It is re-sampled in IDLE after completion.
- Latency: busy=1 and the first write slot are presented in the cycle right after the accepting edge.
- CLEAR:
  - Emits exactly WIDTH*HEIGHT consecutive cycles with write_enable=1.
  - Raster order from (0,0): X increments fastest and wraps WIDTH-1 -> 0 with Y+1. Last slot is (WIDTH-1, HEIGHT-1).
  - write_color = latched colour throughout.
- BRUSH:
  - Emits exactly (2R+1)^2 slots, R=BRUSH_RADIUS.
  - Offsets dy = -R..R (outer loop) and dx = -R..R (inner loop).
  - Pixel = (cx+dx, cy+dy), computed in 11-bit signed arithmetic so cx-R below 0 is detected.
  - write_enable=1 only when 0 <= px < WIDTH and 0 <= py < HEIGHT; otherwise the slot is still consumed with write_enable=0.
  - writeX/writeY in a clipped slot hold don't-care values.
  - A centre wholly outside the buffer yields (2R+1)^2 slots with no writes, then done.
- Completion:
  - On the edge ending the final slot: state -> IDLE, busy -> 0, write_enable -> 0, done -> 1 for exactly one cycle.
  - A request present during the done cycle is accepted on the following edge.
  - Back-to-back operations therefore have one idle slot between them.
- Requests while busy: ignored entirely. Latched operands do not change mid-operation when the inputs change.
- rst mid-operation: on that edge return to IDLE with all outputs at reset values. The operation is abandoned with no done pulse. Partially written pixels remain in the framebuffer.
- Counter widths: X/Y counters are sized with $clog2 of WIDTH/HEIGHT. The brush offset counter is sized from 2R+1.
- Wrap: no wrap-around of brush pixels across edges; clipping only.

Test Plan:
Bench parameters: WIDTH=8, HEIGHT=4, BRUSH_RADIUS=1.
- Clear: clear_req=1, clear_color=2 for one cycle.
  - busy=1 for 32 cycles; 32 writes with colour 2 in raster order (0,0),(1,0)..(7,3).
  - done pulses once, 1 cycle, immediately after write 32.
- Interior brush: paint_req with (4,2), colour 1.
  - 9 slots, all write_enable=1, in order (3,1),(4,1),(5,1),(3,2)..(5,3); then done.
- Corner clip: paint at (0,0).
  - Still 9 slots; only (0,0),(1,0),(0,1),(1,1) written, enables in slot positions 5,6,8,9; done after slot 9.
- Priority and ignore-while-busy:
  - clear_req and paint_req asserted together -> CLEAR runs.
  - paint_x changed mid-clear has no effect.
  - Paint held high through the done cycle -> BRUSH accepted on the next edge with the then-current operands.
- Reset mid-clear: assert rst at write 10.
  - Next cycle write_enable=0, busy=0, no done pulse.
  - A subsequent paint_req behaves as in the interior-brush case.
- Off-screen centre: paint at (20,20) -> 9 slots with write_enable=0 throughout, then done=1.
